// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and instruction memory.
//   mem_req   : read request, held until mem_ack
//   mem_addr  : read address, stable while mem_req = 1
//   mem_ack   : one-cycle pulse, mem_rdata valid
//   mem_rdata : instruction word
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one memory read per PC value, hands the
// word to decode through an output register backed by a one-entry skid buffer,
// and holds the PC (stall) until the fetch at the current address is captured.
//   Clk, Clrn  : clock, asynchronous active-low reset
//   pc         : current PC value
//   flush      : redirect, PC loads a branch/jump target this cycle
//   id_stall   : decode cannot accept an instruction this cycle
//   stall      : combinational PC hold (1 = hold)
//   mem        : instruction-memory read bus (master side)
//   inst, inst_pc, inst_valid : instruction to decode, its address, valid flag
module fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              id_stall,
  output logic              stall,
  fetch_ctrl_if.master      mem,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FULL} state_t;

  state_t            state, state_n;
  logic              req_q, req_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       inst_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic              inst_valid_n;
  logic [31:0]       skid_data, skid_data_n;
  logic [ADDR_W-1:0] skid_pc, skid_pc_n;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  // PC advances only on the cycle the fetch at its address is acknowledged,
  // or immediately on redirect.
  assign stall = flush ? 1'b0 : !((state == WAIT) && mem.mem_ack);

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      skid_data  <= NOP_INST;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      req_q      <= req_n;
      addr_q     <= addr_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
      skid_data  <= skid_data_n;
      skid_pc    <= skid_pc_n;
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    state_n      = state;
    req_n        = req_q;
    addr_n       = addr_q;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid && id_stall;  // decode consumes when not stalled
    skid_data_n  = skid_data;
    skid_pc_n    = skid_pc;

    unique case (state)
      IDLE: begin
        // On redirect the new target is issued on the following cycle.
        if (!flush) begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          if (mem.mem_ack) begin
            req_n   = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = DRAIN;
          end
        end else if (mem.mem_ack) begin
          req_n = 1'b0;
          if (!inst_valid || !id_stall) begin
            inst_n       = mem.mem_rdata;
            inst_pc_n    = addr_q;
            inst_valid_n = 1'b1;
            state_n      = IDLE;
          end else begin
            skid_data_n = mem.mem_rdata;
            skid_pc_n   = addr_q;
            state_n     = FULL;
          end
        end
      end
      FULL: begin
        if (flush) begin
          state_n = IDLE;
        end else if (!id_stall) begin
          inst_n       = skid_data;
          inst_pc_n    = skid_pc;
          inst_valid_n = 1'b1;
          state_n      = IDLE;
        end
      end
      DRAIN: begin
        // Outstanding read from before the redirect; its data is dropped.
        if (mem.mem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Redirect discards everything already fetched.
    if (flush) begin
      inst_valid_n = 1'b0;
      inst_n       = NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl_if #(.ADDR_W(32)) mif ();

  fetch_ctrl #(.NOP_INST(32'h0000_0000), .ADDR_W(32)) dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .pc        (pc),
    .flush     (flush),
    .id_stall  (id_stall),
    .stall     (stall),
    .mem       (mif),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge; registered outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clrn = 1'b0; pc = '0; flush = 1'b0; id_stall = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    #3;
    n_vec++; if (mif.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", mif.mem_req); end
    n_vec++; if (mif.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", mif.mem_addr); end
    n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", inst); end
    n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall got %b want 1", stall); end
    tick();
    Clrn = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      d = 32'hC0DE_0000 | a;
      pc = a;
      #1;
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL zw_idle_stall[%0d] got %b want 1", i, stall); end
      tick();
      n_vec++; if (mif.mem_req !== 1'b1) begin n_err++; $display("FAIL zw_req[%0d] got %b want 1", i, mif.mem_req); end
      n_vec++; if (mif.mem_addr !== a) begin n_err++; $display("FAIL zw_addr[%0d] got %h want %h", i, mif.mem_addr, a); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL zw_valid_lo[%0d] got %b want 0", i, inst_valid); end
      mif.mem_ack = 1'b1; mif.mem_rdata = d;
      #1;
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zw_ack_stall[%0d] got %b want 0", i, stall); end
      tick();
      mif.mem_ack = 1'b0;
      pc = a + 32'd4;
      n_vec++; if (mif.mem_req !== 1'b0) begin n_err++; $display("FAIL zw_req_drop[%0d] got %b want 0", i, mif.mem_req); end
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d] got %b want 1", i, inst_valid); end
      n_vec++; if (inst !== d) begin n_err++; $display("FAIL zw_inst[%0d] got %h want %h", i, inst, d); end
      n_vec++; if (inst_pc !== a) begin n_err++; $display("FAIL zw_inst_pc[%0d] got %h want %h", i, inst_pc, a); end
    end
  endtask

  task automatic test_wait_states();
    pc = 32'h10;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h10) begin n_err++; $display("FAIL ws_hold[%0d] got req=%b addr=%h want 1/10", i, mif.mem_req, mif.mem_addr); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ws_stall[%0d] got %b want 1", i, stall); end
      tick();
    end
    n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h10) begin n_err++; $display("FAIL ws_hold4 got req=%b addr=%h want 1/10", mif.mem_req, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hA5A5_0010;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ws_ack_stall got %b want 0", stall); end
    tick();
    mif.mem_ack = 1'b0;
    pc = 32'h14;
    n_vec++; if (inst !== 32'hA5A5_0010 || inst_pc !== 32'h10 || inst_valid !== 1'b1) begin n_err++; $display("FAIL ws_out got %h@%h v=%b want a5a50010@10 v=1", inst, inst_pc, inst_valid); end
  endtask

  task automatic test_back_to_back();
    pc = 32'h20;
    tick();
    id_stall = 1'b1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hD000_0020;
    tick();
    mif.mem_ack = 1'b0;
    pc = 32'h24;
    n_vec++; if (inst !== 32'hD000_0020 || inst_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first got %h v=%b want d0000020 v=1", inst, inst_valid); end
    tick();
    n_vec++; if (mif.mem_addr !== 32'h24 || mif.mem_req !== 1'b1) begin n_err++; $display("FAIL b2b_req2 got req=%b addr=%h want 1/24", mif.mem_req, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hD000_0024;
    tick();
    mif.mem_ack = 1'b0;
    pc = 32'h28;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (mif.mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_full_req[%0d] got %b want 0", i, mif.mem_req); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_full_stall[%0d] got %b want 1", i, stall); end
      n_vec++; if (inst !== 32'hD000_0020 || inst_pc !== 32'h20 || inst_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold[%0d] got %h@%h v=%b want d0000020@20 v=1", i, inst, inst_pc, inst_valid); end
      tick();
    end
    id_stall = 1'b0;
    tick();
    n_vec++; if (inst !== 32'hD000_0024 || inst_pc !== 32'h24 || inst_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got %h@%h v=%b want d0000024@24 v=1", inst, inst_pc, inst_valid); end
    tick();
    n_vec++; if (mif.mem_addr !== 32'h28 || inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_next got addr=%h v=%b want 28 v=0", mif.mem_addr, inst_valid); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hD000_0028;
    tick();
    mif.mem_ack = 1'b0;
    pc = 32'h30;
  endtask

  task automatic test_flush_wait();
    tick();
    n_vec++; if (mif.mem_addr !== 32'h30) begin n_err++; $display("FAIL fw_addr got %h want 30", mif.mem_addr); end
    flush = 1'b1; pc = 32'h100;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fw_flush_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h30) begin n_err++; $display("FAIL fw_drain_hold got req=%b addr=%h want 1/30", mif.mem_req, mif.mem_addr); end
    n_vec++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin n_err++; $display("FAIL fw_drain_out got %h v=%b want 0 v=0", inst, inst_valid); end
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL fw_drain_stall got %b want 1", stall); end
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL fw_drain_ack_stall got %b want 1", stall); end
    tick();
    mif.mem_ack = 1'b0;
    n_vec++; if (inst === 32'hDEAD_BEEF || inst_valid !== 1'b0 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL fw_discard got %h v=%b req=%b want 0 v=0 req=0", inst, inst_valid, mif.mem_req); end
    tick();
    n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100) begin n_err++; $display("FAIL fw_target got req=%b addr=%h want 1/100", mif.mem_req, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111_0100;
    tick();
    mif.mem_ack = 1'b0;
    pc = 32'h104;
    n_vec++; if (inst !== 32'h1111_0100 || inst_pc !== 32'h100 || inst_valid !== 1'b1) begin n_err++; $display("FAIL fw_target_out got %h@%h v=%b want 11110100@100 v=1", inst, inst_pc, inst_valid); end
  endtask

  task automatic test_flush_ack_full();
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_0104; flush = 1'b1; pc = 32'h200;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fa_stall got %b want 0", stall); end
    tick();
    mif.mem_ack = 1'b0; flush = 1'b0;
    n_vec++; if (inst_valid !== 1'b0 || inst !== 32'h0 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL fa_drop got %h v=%b req=%b want 0 v=0 req=0", inst, inst_valid, mif.mem_req); end
    tick();
    n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h200) begin n_err++; $display("FAIL fa_target got req=%b addr=%h want 1/200", mif.mem_req, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h2222_0200;
    tick();
    mif.mem_ack = 1'b0; pc = 32'h204; id_stall = 1'b1;
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_0204;
    tick();
    mif.mem_ack = 1'b0;
    n_vec++; if (inst !== 32'h2222_0200 || inst_valid !== 1'b1 || mif.mem_req !== 1'b0) begin n_err++; $display("FAIL ff_full got %h v=%b req=%b want 22220200 v=1 req=0", inst, inst_valid, mif.mem_req); end
    flush = 1'b1; pc = 32'h300;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ff_stall got %b want 0", stall); end
    tick();
    flush = 1'b0; id_stall = 1'b0;
    n_vec++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin n_err++; $display("FAIL ff_drop got %h v=%b want 0 v=0", inst, inst_valid); end
    tick();
    n_vec++; if (mif.mem_addr !== 32'h300 || inst_valid !== 1'b0 || inst === 32'hBAD0_0204) begin n_err++; $display("FAIL ff_target got addr=%h v=%b inst=%h want 300 v=0", mif.mem_addr, inst_valid, inst); end
  endtask

  task automatic test_reset_mid();
    #2;
    Clrn = 1'b0; pc = 32'h0;
    #1;
    n_vec++; if (mif.mem_req !== 1'b0 || inst_valid !== 1'b0 || mif.mem_addr !== 32'h0) begin n_err++; $display("FAIL rm_clear got req=%b v=%b addr=%h want 0/0/0", mif.mem_req, inst_valid, mif.mem_addr); end
    tick();
    Clrn = 1'b1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_0300;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_stray_stall got %b want 1", stall); end
    tick();
    mif.mem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin n_err++; $display("FAIL rm_stray_out got %h v=%b want 0 v=0", inst, inst_valid); end
    n_vec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin n_err++; $display("FAIL rm_first_req got req=%b addr=%h want 1/0", mif.mem_req, mif.mem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_flush_wait();
    test_flush_ack_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
